flash_reader: RTL and testbench

SPI NOR flash streaming reader that feeds cartridge loading. cart_mem asserts a request with a flash byte address and length; the block issues a standard READ (0x03) command and streams bytes back one at a time. cart_mem writes those bytes into PRG/CHR storage. The block owns the physical flash_csn/flash_sck/flash_mosi/flash_miso pins.

---
 rtl/flash_reader_pkg.sv | 18 +
 rtl/flash_reader_if.sv | 35 +++
 rtl/flash_reader_spi_shifter.sv | 84 ++++++++
 rtl/flash_reader.sv | 154 +++++++++++++++
 tb/tb_flash_reader.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/flash_reader_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------
// flash_pkg : shared constants and state encoding for flash_reader. Rev 1.0
// ----------------------------------------------------------------------
package flash_pkg;

  localparam logic [7:0] FLASH_CMD_READ = 8'h03;
  localparam int         CMD_BITS       = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    DATA = 2'd2,
    GAP  = 2'd3
  } state_e;

endpackage
`default_nettype wire

// File: rtl/flash_reader_if.sv
`default_nettype none
// ----------------------------------------------------------------------
// flash_reader_if : request/stream handshake plus SPI flash pins. Rev 1.0
// ----------------------------------------------------------------------
interface flash_reader_if #(
  parameter int ADDR_W = 24,
  parameter int LEN_W  = 24
);
  import flash_pkg::*;

  logic              req;
  logic [ADDR_W-1:0] start_addr;
  logic [LEN_W-1:0]  length;
  logic              busy;
  logic              data_valid;
  logic [7:0]        data;
  logic              done;
  logic              flash_csn;
  logic              flash_sck;
  logic              flash_mosi;
  logic              flash_miso;

  // Master is the cart loader side together with the flash device pins.
  modport master (
    output req, start_addr, length, flash_miso,
    input  busy, data_valid, data, done, flash_csn, flash_sck, flash_mosi
  );

  modport slave (
    input  req, start_addr, length, flash_miso,
    output busy, data_valid, data, done, flash_csn, flash_sck, flash_mosi
  );

endinterface
`default_nettype wire

// File: rtl/flash_reader_spi_shifter.sv
`default_nettype none
// ----------------------------------------------------------------------
// spi_shifter : mode-0 SCK divider, 32-bit MSB-first TX, 8-bit RX. Rev 1.0
// ----------------------------------------------------------------------
module spi_shifter
  import flash_pkg::*;
#(
  parameter int CLK_DIV = 2
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                load_i,
  input  logic [CMD_BITS-1:0] word_i,
  input  logic                stop_i,
  input  logic                miso_i,
  output logic                sck_o,
  output logic                mosi_o,
  output logic                rise_o,
  output logic                fall_o,
  output logic [7:0]          rx_o
);

  localparam int               DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic                en_q;
  logic                high_q;
  logic [DIV_W-1:0]    div_q;
  logic [CMD_BITS-1:0] tx_q;
  logic [7:0]          rx_q;
  logic                sck_q;
  logic                mosi_q;
  logic                tick_d;

  assign tick_d = en_q && (div_q == DIV_LAST);
  assign rise_o = tick_d && !high_q;
  assign fall_o = tick_d && high_q;
  assign sck_o  = sck_q;
  assign mosi_o = mosi_q;
  assign rx_o   = rx_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      en_q   <= 1'b0;
      high_q <= 1'b0;
      div_q  <= '0;
      tx_q   <= '0;
      rx_q   <= 8'h00;
      sck_q  <= 1'b0;
      mosi_q <= 1'b0;
    end else if (load_i) begin
      en_q   <= 1'b1;
      high_q <= 1'b0;
      div_q  <= '0;
      sck_q  <= 1'b0;
      mosi_q <= word_i[CMD_BITS-1];
      tx_q   <= {word_i[CMD_BITS-2:0], 1'b0};
    end else if (en_q) begin
      if (tick_d) begin
        div_q <= '0;
        if (!high_q) begin
          high_q <= 1'b1;
          sck_q  <= 1'b1;
          rx_q   <= {rx_q[6:0], miso_i};
        end else begin
          high_q <= 1'b0;
          sck_q  <= 1'b0;
          // TX runs out of command bits after 32 shifts, so MOSI is 0 during data.
          if (stop_i) begin
            en_q   <= 1'b0;
            mosi_q <= 1'b0;
          end else begin
            mosi_q <= tx_q[CMD_BITS-1];
            tx_q   <= {tx_q[CMD_BITS-2:0], 1'b0};
          end
        end
      end else begin
        div_q <= div_q + DIV_W'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/flash_reader.sv
`default_nettype none
// ----------------------------------------------------------------------
// flash_reader : SPI NOR READ (0x03) streaming reader, FSM + counters. Rev 1.0
// ----------------------------------------------------------------------
module flash_reader
  import flash_pkg::*;
#(
  parameter int CLK_DIV = 2,
  parameter int ADDR_W  = 24,
  parameter int LEN_W   = 24
) (
  input  logic          clock,
  input  logic          reset,
  flash_reader_if.slave bus
);

  localparam int               ADDR_BITS = CMD_BITS - 8;
  localparam int               GAP_W     = $clog2(2 * CLK_DIV);
  localparam logic [GAP_W-1:0] GAP_INIT  = GAP_W'(2 * CLK_DIV - 1);

  state_e             state_q;
  logic [LEN_W-1:0]   remain_q;
  logic [4:0]         bit_cnt_q;
  logic [GAP_W-1:0]   gap_q;
  logic               zero_q;
  logic               byte_pend_q;
  logic               csn_q;
  logic               busy_q;
  logic               dv_q;
  logic               done_q;
  logic [7:0]         data_q;

  logic [ADDR_W-1:0]   addr_d;
  logic [CMD_BITS-1:0] word_d;
  logic                load_d;
  logic                stop_d;
  logic                rise_d;
  logic                fall_d;
  logic [7:0]          rx_d;

  assign addr_d = bus.start_addr;
  assign word_d = {FLASH_CMD_READ, addr_d[ADDR_BITS-1:0]};
  assign load_d = (state_q == IDLE) && bus.req && (bus.length != '0);
  assign stop_d = (state_q == DATA) && fall_d && (remain_q == '0);

  spi_shifter #(
    .CLK_DIV (CLK_DIV)
  ) u_shifter (
    .clock  (clock),
    .reset  (reset),
    .load_i (load_d),
    .word_i (word_d),
    .stop_i (stop_d),
    .miso_i (bus.flash_miso),
    .sck_o  (bus.flash_sck),
    .mosi_o (bus.flash_mosi),
    .rise_o (rise_d),
    .fall_o (fall_d),
    .rx_o   (rx_d)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      remain_q    <= '0;
      bit_cnt_q   <= 5'd0;
      gap_q       <= '0;
      zero_q      <= 1'b0;
      byte_pend_q <= 1'b0;
      csn_q       <= 1'b1;
      busy_q      <= 1'b0;
      dv_q        <= 1'b0;
      done_q      <= 1'b0;
      data_q      <= 8'h00;
    end else begin
      dv_q        <= 1'b0;
      byte_pend_q <= 1'b0;
      // The shifter's RX register holds the full byte one cycle after the 8th sample.
      if (byte_pend_q) begin
        data_q <= rx_d;
        dv_q   <= 1'b1;
      end
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (bus.req) begin
            busy_q <= 1'b1;
            if (bus.length == '0) begin
              zero_q  <= 1'b1;
              gap_q   <= '0;
              state_q <= GAP;
            end else begin
              zero_q    <= 1'b0;
              remain_q  <= bus.length;
              bit_cnt_q <= 5'd0;
              csn_q     <= 1'b0;
              state_q   <= CMD;
            end
          end
        end
        CMD: begin
          if (fall_d) begin
            if (bit_cnt_q == 5'd31) begin
              bit_cnt_q <= 5'd0;
              state_q   <= DATA;
            end else begin
              bit_cnt_q <= bit_cnt_q + 5'd1;
            end
          end
        end
        DATA: begin
          if (rise_d) begin
            if (bit_cnt_q == 5'd7) begin
              bit_cnt_q   <= 5'd0;
              remain_q    <= remain_q - LEN_W'(1);
              byte_pend_q <= 1'b1;
            end else begin
              bit_cnt_q <= bit_cnt_q + 5'd1;
            end
          end
          if (stop_d) begin
            csn_q   <= 1'b1;
            gap_q   <= GAP_INIT;
            state_q <= GAP;
          end
        end
        GAP: begin
          // A zero-length request drops busy as done rises; a real transfer keeps busy through done.
          if (done_q) begin
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else if (gap_q == '0) begin
            done_q <= 1'b1;
            if (zero_q) begin
              busy_q <= 1'b0;
            end
          end else begin
            gap_q <= gap_q - GAP_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.flash_csn  = csn_q;
  assign bus.busy       = busy_q;
  assign bus.data_valid = dv_q;
  assign bus.data       = data_q;
  assign bus.done       = done_q;

endmodule
`default_nettype wire

// File: tb/tb_flash_reader.sv
`default_nettype none
// ----------------------------------------------------------------------
// tb_flash_reader : directed bench, instance 0 at CLK_DIV=2, instance 1 at CLK_DIV=1. Rev 1.0
// ----------------------------------------------------------------------
module tb_flash_reader;

  logic clock   = 1'b0;
  logic reset   = 1'b1;
  logic clr_mon = 1'b0;
  int   cyc     = 0;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int DIV = (g == 0) ? 2 : 1;

    flash_reader_if #(.ADDR_W(24), .LEN_W(24)) bus ();

    flash_reader #(
      .CLK_DIV (DIV),
      .ADDR_W  (24),
      .LEN_W   (24)
    ) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus.slave)
    );

    logic [7:0]  mem [0:7];
    logic [7:0]  dv_d [0:7];
    int          dv_cyc [0:7];
    logic [31:0] cmd_word = '0;
    int          rise_cnt = 0, csn_low = 0, sck_edges = 0, dv_cnt = 0;
    int          done_cnt = 0, done_cyc = 0, busy_cnt = 0, csn_rise_cyc = 0;
    int          k;
    logic        prev_sck = 1'b0, prev_csn = 1'b1;

    // Observation counters plus a flash device: MISO shifts on SCK fall after the 32 command bits.
    always @(negedge clock) begin
      if (clr_mon) begin
        cmd_word <= '0; csn_low <= 0; sck_edges <= 0; dv_cnt <= 0;
        done_cnt <= 0; done_cyc <= 0; busy_cnt <= 0; csn_rise_cyc <= 0;
      end else begin
        if (!bus.flash_csn) csn_low <= csn_low + 1;
        if (bus.flash_sck != prev_sck) sck_edges <= sck_edges + 1;
        if (bus.busy) busy_cnt <= busy_cnt + 1;
        if (bus.data_valid) begin
          if (dv_cnt < 8) begin
            dv_d[dv_cnt]   <= bus.data;
            dv_cyc[dv_cnt] <= cyc;
          end
          dv_cnt <= dv_cnt + 1;
        end
        if (bus.done) begin
          done_cnt <= done_cnt + 1;
          done_cyc <= cyc;
        end
        if (bus.flash_csn && !prev_csn) csn_rise_cyc <= cyc;
      end
      k = rise_cnt - 32;
      if (bus.flash_csn) begin
        rise_cnt       <= 0;
        bus.flash_miso <= 1'b0;
      end else if (bus.flash_sck && !prev_sck) begin
        rise_cnt <= rise_cnt + 1;
        if (rise_cnt < 32) cmd_word <= {cmd_word[30:0], bus.flash_mosi};
      end else if (!bus.flash_sck && prev_sck && rise_cnt >= 32) begin
        bus.flash_miso <= mem[k[5:3]][3'd7 - k[2:0]];
      end
      prev_sck <= bus.flash_sck;
      prev_csn <= bus.flash_csn;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int done_cnt_of(input int g);
    return (g == 0) ? g_dut[0].done_cnt : g_dut[1].done_cnt;
  endfunction

  function automatic int dv_cnt_of(input int g);
    return (g == 0) ? g_dut[0].dv_cnt : g_dut[1].dv_cnt;
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #2;
  endtask

  task automatic clear();
    clr_mon = 1'b1;
    step(1);
    clr_mon = 1'b0;
  endtask

  task automatic start(input int g, input logic [23:0] addr, input logic [23:0] len);
    if (g == 0) begin
      g_dut[0].bus.req = 1'b1; g_dut[0].bus.start_addr = addr; g_dut[0].bus.length = len;
    end else begin
      g_dut[1].bus.req = 1'b1; g_dut[1].bus.start_addr = addr; g_dut[1].bus.length = len;
    end
    step(1);
    g_dut[0].bus.req = 1'b0;
    g_dut[1].bus.req = 1'b0;
  endtask

  task automatic wait_done(input int g, input int budget, input string tag);
    for (int i = 0; i < budget && done_cnt_of(g) == 0; i++) step(1);
    chk(tag, 32'(done_cnt_of(g) != 0), 32'd1);
    step(6);
  endtask

  task automatic wait_dv(input int g, input int n, input int budget, input string tag);
    for (int i = 0; i < budget && dv_cnt_of(g) < n; i++) step(1);
    chk(tag, 32'(dv_cnt_of(g) >= n), 32'd1);
  endtask

  int req_cyc;

  initial begin
    g_dut[0].bus.req = 1'b0; g_dut[0].bus.start_addr = '0; g_dut[0].bus.length = '0;
    g_dut[1].bus.req = 1'b0; g_dut[1].bus.start_addr = '0; g_dut[1].bus.length = '0;
    for (int i = 0; i < 8; i++) begin
      g_dut[0].mem[i] = 8'h00;
      g_dut[1].mem[i] = 8'h00;
    end

    // Reset values
    step(5);
    chk("rst_csn",  32'(g_dut[0].bus.flash_csn),  32'd1);
    chk("rst_sck",  32'(g_dut[0].bus.flash_sck),  32'd0);
    chk("rst_mosi", 32'(g_dut[0].bus.flash_mosi), 32'd0);
    chk("rst_busy", 32'(g_dut[0].bus.busy),       32'd0);
    chk("rst_dv",   32'(g_dut[0].bus.data_valid), 32'd0);
    chk("rst_done", 32'(g_dut[0].bus.done),       32'd0);
    chk("rst_data", 32'(g_dut[0].bus.data),       32'h00);
    chk("rst_csn1", 32'(g_dut[1].bus.flash_csn),  32'd1);
    reset = 1'b0;
    step(2);

    // Single byte, CLK_DIV=2
    clear();
    g_dut[0].mem[0] = 8'hA5;
    start(0, 24'h100000, 24'd1);
    wait_done(0, 1000, "a_timeout");
    chk("a_cmd",      g_dut[0].cmd_word,                             32'h03100000);
    chk("a_dv_cnt",   32'(g_dut[0].dv_cnt),                          32'd1);
    chk("a_byte0",    32'(g_dut[0].dv_d[0]),                         32'hA5);
    chk("a_data_hold",32'(g_dut[0].bus.data),                        32'hA5);
    chk("a_csn_low",  32'(g_dut[0].csn_low),                         32'd160);
    chk("a_done_cnt", 32'(g_dut[0].done_cnt),                        32'd1);
    chk("a_gap",      32'(g_dut[0].done_cyc - g_dut[0].csn_rise_cyc), 32'd4);
    chk("a_busy_len", 32'(g_dut[0].busy_cnt),                        32'd165);
    chk("a_busy_end", 32'(g_dut[0].bus.busy),                        32'd0);

    // Streaming, CLK_DIV=1
    clear();
    g_dut[1].mem[0] = 8'h01; g_dut[1].mem[1] = 8'h02;
    g_dut[1].mem[2] = 8'h03; g_dut[1].mem[3] = 8'h04;
    start(1, 24'h000040, 24'd4);
    wait_done(1, 1000, "b_timeout");
    chk("b_cmd",      g_dut[1].cmd_word,                             32'h03000040);
    chk("b_dv_cnt",   32'(g_dut[1].dv_cnt),                          32'd4);
    chk("b_byte0",    32'(g_dut[1].dv_d[0]),                         32'h01);
    chk("b_byte1",    32'(g_dut[1].dv_d[1]),                         32'h02);
    chk("b_byte2",    32'(g_dut[1].dv_d[2]),                         32'h03);
    chk("b_byte3",    32'(g_dut[1].dv_d[3]),                         32'h04);
    chk("b_space01",  32'(g_dut[1].dv_cyc[1] - g_dut[1].dv_cyc[0]),  32'd16);
    chk("b_space23",  32'(g_dut[1].dv_cyc[3] - g_dut[1].dv_cyc[2]),  32'd16);
    chk("b_csn_low",  32'(g_dut[1].csn_low),                         32'd128);
    chk("b_done_cnt", 32'(g_dut[1].done_cnt),                        32'd1);

    // Length zero
    clear();
    req_cyc = cyc;
    start(0, 24'h000055, 24'd0);
    step(8);
    chk("z_csn_low",  32'(g_dut[0].csn_low),                32'd0);
    chk("z_sck_edge", 32'(g_dut[0].sck_edges),              32'd0);
    chk("z_busy_len", 32'(g_dut[0].busy_cnt),               32'd1);
    chk("z_dv_cnt",   32'(g_dut[0].dv_cnt),                 32'd0);
    chk("z_done_cnt", 32'(g_dut[0].done_cnt),               32'd1);
    chk("z_done_lat", 32'(g_dut[0].done_cyc - req_cyc),     32'd2);

    // Request while busy is ignored
    clear();
    g_dut[1].mem[0] = 8'hAA; g_dut[1].mem[1] = 8'h55;
    start(1, 24'h123456, 24'd2);
    wait_dv(1, 1, 400, "d_dv_timeout");
    start(1, 24'hFFFFFF, 24'd3);
    wait_done(1, 1000, "d_timeout");
    step(20);
    chk("d_cmd",      g_dut[1].cmd_word,         32'h03123456);
    chk("d_dv_cnt",   32'(g_dut[1].dv_cnt),      32'd2);
    chk("d_byte0",    32'(g_dut[1].dv_d[0]),     32'hAA);
    chk("d_byte1",    32'(g_dut[1].dv_d[1]),     32'h55);
    chk("d_done_cnt", 32'(g_dut[1].done_cnt),    32'd1);
    chk("d_csn_low",  32'(g_dut[1].csn_low),     32'd96);

    // Reset mid-transfer, then a clean request
    clear();
    g_dut[0].mem[0] = 8'h11; g_dut[0].mem[1] = 8'h22;
    g_dut[0].mem[2] = 8'h33; g_dut[0].mem[3] = 8'h44;
    start(0, 24'h0ABCDE, 24'd4);
    wait_dv(0, 2, 1000, "e_dv_timeout");
    reset = 1'b1;
    #1;
    chk("e_async_csn",  32'(g_dut[0].bus.flash_csn), 32'd1);
    chk("e_async_sck",  32'(g_dut[0].bus.flash_sck), 32'd0);
    chk("e_async_busy", 32'(g_dut[0].bus.busy),      32'd0);
    step(2);
    reset = 1'b0;
    step(100);
    chk("e_dv_after",   32'(g_dut[0].dv_cnt),        32'd2);
    chk("e_no_done",    32'(g_dut[0].done_cnt),      32'd0);
    clear();
    g_dut[0].mem[0] = 8'h5A;
    start(0, 24'h020304, 24'd1);
    wait_done(0, 1000, "e_timeout");
    chk("e_cmd",      g_dut[0].cmd_word,        32'h03020304);
    chk("e_dv_cnt",   32'(g_dut[0].dv_cnt),     32'd1);
    chk("e_byte0",    32'(g_dut[0].dv_d[0]),    32'h5A);
    chk("e_done_cnt", 32'(g_dut[0].done_cnt),   32'd1);
    chk("e_csn_low",  32'(g_dut[0].csn_low),    32'd160);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
